// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: replays a small table of register writes over an
// Avalon-MM master, then supervises lock with a single reset-and-retry on timeout.
module pll_cfg_seq #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_we,
  input  logic [2:0]  ld_idx,
  input  logic [5:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        cfg_go,
  input  logic [3:0]  cfg_len,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        locked_s
);

  localparam int unsigned TW      = $clog2(TIMEOUT + 1);
  localparam int unsigned RW      = $clog2(RST_CYCLES + 1);
  localparam int unsigned IW      = $clog2(DEPTH);
  localparam logic [3:0]  LEN_MAX = 4'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, MODE, WRITE, START, BLANK, WAIT_LOCK, RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    len_q, len_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    lcnt_q, lcnt_d;
  logic          retry_q, retry_d;
  logic          boot_q, boot_d;
  logic          sync1_q, locked_s_q, lock_prev_q;

  logic          mgmt_write_q, mgmt_write_d;
  logic [5:0]    mgmt_address_q, mgmt_address_d;
  logic [31:0]   mgmt_writedata_q, mgmt_writedata_d;
  logic          busy_q, busy_d;
  logic          pll_rst_q, pll_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [37:0]   tbl_mem [DEPTH];
  logic [37:0]   entry;
  logic          xfer_ok, lock_hit, tmo_hit, lock_fall;

  // Table survives rst on purpose; loads only while the sequencer is quiescent.
  always_ff @(posedge clk) begin
    if (ld_we && (state_q == IDLE) && !cfg_go) begin
      tbl_mem[ld_idx[IW-1:0]] <= {ld_addr, ld_data};
    end
  end

  assign xfer_ok   = mgmt_write_q && !mgmt_waitrequest;
  assign lock_hit  = locked_s_q && (lcnt_q == 3'd7);
  assign tmo_hit   = (tcnt_q == TW'(TIMEOUT - 1));
  assign lock_fall = lock_prev_q && !locked_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      len_q            <= '0;
      bcnt_q           <= '0;
      rcnt_q           <= '0;
      tcnt_q           <= '0;
      lcnt_q           <= '0;
      retry_q          <= 1'b0;
      boot_q           <= 1'b1;
      sync1_q          <= 1'b0;
      locked_s_q       <= 1'b0;
      lock_prev_q      <= 1'b0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= '0;
      mgmt_writedata_q <= '0;
      busy_q           <= 1'b0;
      pll_rst_q        <= 1'b1;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      len_q            <= len_d;
      bcnt_q           <= bcnt_d;
      rcnt_q           <= rcnt_d;
      tcnt_q           <= tcnt_d;
      lcnt_q           <= lcnt_d;
      retry_q          <= retry_d;
      boot_q           <= boot_d;
      sync1_q          <= pll_locked;
      locked_s_q       <= sync1_q;
      lock_prev_q      <= locked_s_q;
      mgmt_write_q     <= mgmt_write_d;
      mgmt_address_q   <= mgmt_address_d;
      mgmt_writedata_q <= mgmt_writedata_d;
      busy_q           <= busy_d;
      pll_rst_q        <= pll_rst_d;
      done_q           <= done_d;
      err_q            <= err_d;
    end
  end

  // boot_q turns the first IDLE cycle after reset into a RECOVER pulse with retry
  // already spent, so the post-reset lock wait ends in err rather than a second reset.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    lcnt_d  = lcnt_q;
    retry_d = retry_q;
    boot_d  = boot_q;
    unique case (state_q)
      IDLE: begin
        if (boot_q) begin
          state_d = RECOVER;
          boot_d  = 1'b0;
          retry_d = 1'b1;
          rcnt_d  = '0;
        end else if (lock_fall) begin
          state_d = RECOVER;
          retry_d = 1'b0;
          rcnt_d  = '0;
        end else if (cfg_go) begin
          state_d = MODE;
          retry_d = 1'b0;
          idx_d   = '0;
          len_d   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        end
      end
      MODE: begin
        if (xfer_ok) begin
          idx_d   = '0;
          state_d = (len_q == 4'd0) ? START : WRITE;
        end
      end
      WRITE: begin
        if (xfer_ok) begin
          if (idx_q == len_q - 4'd1) state_d = START;
          else                       idx_d   = idx_q + 4'd1;
        end
      end
      START: begin
        if (xfer_ok) begin
          state_d = BLANK;
          bcnt_d  = '0;
        end
      end
      BLANK: begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          state_d = WAIT_LOCK;
          tcnt_d  = '0;
          lcnt_d  = '0;
        end
      end
      WAIT_LOCK: begin
        tcnt_d = tcnt_q + TW'(1);
        lcnt_d = locked_s_q ? lcnt_q + 3'd1 : 3'd0;
        if (lock_hit) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          if (retry_q) begin
            state_d = IDLE;
          end else begin
            state_d = RECOVER;
            retry_d = 1'b1;
            rcnt_d  = '0;
          end
        end
      end
      RECOVER: begin
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          tcnt_d  = '0;
          lcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write is issued in the cycle after a gap and held until waitrequest drops.
  always_comb begin
    entry            = tbl_mem[idx_d[IW-1:0]];
    mgmt_write_d     = 1'b0;
    mgmt_address_d   = '0;
    mgmt_writedata_d = '0;
    unique case (state_q)
      IDLE:               mgmt_write_d = (state_d == MODE);
      MODE, WRITE, START: mgmt_write_d = mgmt_write_q ? mgmt_waitrequest : 1'b1;
      default:            mgmt_write_d = 1'b0;
    endcase
    if (mgmt_write_d) begin
      unique case (state_d)
        WRITE:   {mgmt_address_d, mgmt_writedata_d} = entry;
        START:   mgmt_address_d = 6'd2;
        default: mgmt_address_d = 6'd0;
      endcase
    end
    busy_d    = (state_d != IDLE);
    pll_rst_d = (state_d == RECOVER);
    done_d    = (state_q == WAIT_LOCK) && lock_hit;
    err_d     = (state_q == WAIT_LOCK) && !lock_hit && tmo_hit && retry_q;
  end

  assign mgmt_write     = mgmt_write_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_writedata = mgmt_writedata_q;
  assign busy           = busy_q;
  assign pll_rst        = pll_rst_q;
  assign done           = done_q;
  assign err            = err_q;
  assign locked_s       = locked_s_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed-plus-random bench for pll_cfg_seq: a table model predicts the write list,
// and lock/timeout/recovery timings are derived from the cycle rules of the sequencer.
module tb_pll_cfg_seq;

  localparam int unsigned T_OUT = 100;
  localparam int unsigned R_CYC = 16;
  localparam int unsigned DEP   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_we = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        cfg_go = 1'b0;
  logic [3:0]  cfg_len = '0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write, pll_rst, busy, done, err, locked_s;

  pll_cfg_seq #(.DEPTH(DEP), .TIMEOUT(T_OUT), .RST_CYCLES(R_CYC)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_idx(ld_idx), .ld_addr(ld_addr),
    .ld_data(ld_data), .cfg_go(cfg_go), .cfg_len(cfg_len),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .pll_rst(pll_rst), .busy(busy), .done(done),
    .err(err), .locked_s(locked_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [5:0]  m_addr [8];
  logic [31:0] m_data [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_entry(input int i, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_idx = 3'(i); ld_addr = a; ld_data = d;
    m_addr[i] = a; m_data[i] = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) load_entry(i, 6'($urandom), $urandom);
  endtask

  // Returns at the negedge just before the edge on which the START write completes.
  task automatic run_writes(input int len, input int hold, input bit rnd);
    logic [5:0]  qa[$];
    logic [31:0] qd[$];
    logic [5:0]  pa;
    logic [31:0] pd;
    int n, done_cnt, holds, xcyc;
    bit prev_wr, prev_cmp, w, cmp, finished;
    n = (len > int'(DEP)) ? int'(DEP) : len;
    qa.push_back(6'd0); qd.push_back(32'd0);
    for (int i = 0; i < n; i++) begin qa.push_back(m_addr[i]); qd.push_back(m_data[i]); end
    qa.push_back(6'd2); qd.push_back(32'd0);
    @(negedge clk);
    cfg_go = 1'b1; cfg_len = 4'(len); pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
    ld_we = 1'b1; ld_idx = 3'd0; ld_addr = ~m_addr[0]; ld_data = ~m_data[0];
    @(negedge clk);
    cfg_go = 1'b0; ld_we = 1'b0;
    chk("busy_after_go", busy, 1);
    done_cnt = 0; holds = 0; xcyc = 0; prev_wr = 0; prev_cmp = 0; finished = 0;
    pa = '0; pd = '0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      ld_we = 1'b0;
      chk("wr_gap_or_issue", mgmt_write, prev_cmp ? 1'b0 : 1'b1);
      if (prev_wr && !prev_cmp) begin
        chk("hold_addr", mgmt_address, pa);
        chk("hold_data", mgmt_writedata, pd);
      end
      if (!mgmt_write) begin
        chk("idle_addr", mgmt_address, 0);
        chk("idle_data", mgmt_writedata, 0);
      end
      w = rnd && ($urandom_range(0, 2) == 0);
      if (mgmt_write && done_cnt == 1 && holds < hold) begin w = 1'b1; holds++; end
      if (cyc == 3) begin
        ld_we = 1'b1; ld_idx = 3'($urandom); ld_addr = 6'($urandom); ld_data = $urandom;
      end
      mgmt_waitrequest = w;
      if (mgmt_write) xcyc++;
      cmp = mgmt_write && !w;
      if (cmp) begin
        chk("xfer_addr", mgmt_address, qa[done_cnt]);
        chk("xfer_data", mgmt_writedata, qd[done_cnt]);
        if (hold > 0 && done_cnt == 1) chk("hold_span", xcyc, hold + 1);
        done_cnt++; xcyc = 0;
        if (done_cnt == qa.size()) finished = 1'b1;
      end
      prev_wr = mgmt_write; prev_cmp = cmp; pa = mgmt_address; pd = mgmt_writedata;
      if (!finished) @(negedge clk);
    end
    ld_we = 1'b0;
    chk("all_writes", done_cnt, qa.size());
  endtask

  // Lock raised d cycles after the START completion sample; done follows 8 synced
  // lock cycles counted from the later of WAIT_LOCK entry and lock visibility.
  task automatic wait_done(input int d);
    int exp_at, got;
    exp_at = (d + 10 > 13) ? d + 10 : 13;
    got = -1;
    if (d == 0) pll_locked = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == d) pll_locked = 1'b1;
      chk("no_write_after_start", mgmt_write, 0);
      if (done === 1'b1 || err === 1'b1) begin got = k; break; end
    end
    chk("done_latency", got, exp_at);
    chk("done_seen", done, 1);
    chk("no_err_with_done", err, 0);
    chk("busy_clear", busy, 0);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  task automatic boot_recover();
    int first, rlen, done_at, wr_seen;
    first = -1; rlen = 0; done_at = -1; wr_seen = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) pll_locked = 1'b1;
      if (pll_rst) begin if (first < 0) first = k; rlen++; end
      if (mgmt_write) wr_seen++;
      if (done === 1'b1) begin done_at = k; break; end
    end
    chk("boot_rst_start", first, 1);
    chk("boot_rst_len", rlen, R_CYC);
    chk("boot_done_at", done_at, 1 + R_CYC + 8);
    chk("boot_no_write", wr_seen, 0);
    chk("boot_no_err", err, 0);
  endtask

  initial begin
    int lens [5];
    int first, rlen, err_at, dn, done_at, cnt;
    bit hit;

    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_write", mgmt_write, 0);
    chk("rst_addr", mgmt_address, 0);
    chk("rst_data", mgmt_writedata, 0);
    chk("rst_locked_s", locked_s, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    boot_recover();

    load_entry(0, 6'h04, 32'h0000_0505);
    load_entry(1, 6'h05, 32'h0002_0202);
    run_writes(2, 0, 1'b0);
    wait_done(10);

    load_random();
    run_writes(3, 5, 1'b0);
    wait_done(0);

    lens = '{0, 8, 9, 15, 0};
    lens[4] = $urandom_range(1, 7);
    for (int it = 0; it < 5; it++) begin
      load_random();
      run_writes(lens[it], 0, 1'b1);
      wait_done($urandom_range(0, 12));
    end

    run_writes($urandom_range(0, 8), 0, 1'b1);
    first = -1; rlen = 0; err_at = -1; dn = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (pll_rst) begin if (first < 0) first = k; rlen++; end
      if (done === 1'b1) dn++;
      if (err === 1'b1) begin err_at = k; break; end
    end
    chk("tmo_rst_start", first, 4 + T_OUT + 1);
    chk("tmo_rst_len", rlen, R_CYC);
    chk("tmo_err_at", err_at, 4 + 2 * T_OUT + R_CYC + 1);
    chk("tmo_no_done", dn, 0);
    @(negedge clk);
    chk("tmo_err_single", err, 0);
    chk("tmo_busy_clear", busy, 0);

    pll_locked = 1'b1;
    repeat (6) @(negedge clk);
    chk("ll_idle_rst", pll_rst, 0);
    chk("ll_idle_busy", busy, 0);
    chk("ll_idle_lock", locked_s, 1);
    pll_locked = 1'b0;
    first = -1; rlen = 0; dn = 0; done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) chk("sync_stage1", locked_s, 1);
      if (k == 2) chk("sync_stage2", locked_s, 0);
      if (pll_rst) begin
        if (first < 0) begin first = k; pll_locked = 1'b1; end
        rlen++;
      end
      if (err === 1'b1) dn++;
      if (done === 1'b1) begin done_at = k; break; end
    end
    chk("ll_rst_start", first, 3);
    chk("ll_rst_len", rlen, R_CYC);
    chk("ll_done_at", done_at, 3 + R_CYC + 8);
    chk("ll_no_err", dn, 0);

    load_random();
    mgmt_waitrequest = 1'b0;
    @(negedge clk);
    cfg_go = 1'b1; cfg_len = 4'd3; pll_locked = 1'b0;
    @(negedge clk);
    cfg_go = 1'b0;
    cnt = 0; hit = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mgmt_write && cnt == 2) begin hit = 1'b1; break; end
      if (mgmt_write && !mgmt_waitrequest) cnt++;
      @(negedge clk);
    end
    chk("mid_hit", hit, 1);
    chk("mid_addr", mgmt_address, m_addr[1]);
    rst = 1'b1;
    #1;
    chk("mid_rst_write", mgmt_write, 0);
    chk("mid_rst_addr", mgmt_address, 0);
    chk("mid_rst_pll_rst", pll_rst, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    boot_recover();
    run_writes($urandom_range(1, 8), 0, 1'b1);
    wait_done($urandom_range(0, 12));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_cfg_seq.md
PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

Interface
REQ-001 Parameter DEPTH, default 8: number of entries in the reconfiguration table.
REQ-002 Parameter TIMEOUT, default 65535: maximum cycles to wait for lock.
REQ-003 Parameter RST_CYCLES, default 16: width of the pll_rst pulse during recovery.
REQ-004 clk  in  1  sequencer clock, the same clock that drives the PLL reconfig management port.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ld_we  in  1  table write strobe.
REQ-007 ld_idx  in  3  table entry index.
REQ-008 ld_addr  in  6  reconfig register address to store.
REQ-009 ld_data  in  32  reconfig register data to store.
REQ-010 cfg_go  in  1  single-cycle start request.
REQ-011 cfg_len  in  4  number of table entries to apply, 0..DEPTH; sampled on cfg_go.
REQ-012 mgmt_address  out  6, mgmt_writedata  out  32, mgmt_write  out  1: Avalon-MM write master to the PLL reconfig block.
REQ-013 mgmt_waitrequest  in  1  slave stall.
REQ-014 pll_locked  in  1  PLL lock; asynchronous to clk.
REQ-015 pll_rst  out  1  PLL reset.
REQ-016 busy  out  1  sequence in progress.
REQ-017 done  out  1  single-cycle pulse on success.
REQ-018 err  out  1  single-cycle pulse on failure.
REQ-019 locked_s  out  1  synchronized lock.

Function
REQ-020 pll_locked SHALL pass through a 2-flop synchronizer; locked_s is the second flop.
REQ-021 ld_we SHALL write {ld_addr, ld_data} to entry ld_idx only when busy=0 and cfg_go=0; otherwise the write is ignored.
REQ-022 Table contents SHALL not be cleared by rst.
REQ-023 States: IDLE, MODE, WRITE, START, BLANK, WAIT_LOCK, RECOVER.
REQ-024 IDLE + cfg_go -> MODE; cfg_len values above DEPTH SHALL be clamped to DEPTH; cfg_go outside IDLE SHALL be ignored.
REQ-025 MODE SHALL write address 0, data 0 (waitrequest mode).
REQ-026 WRITE SHALL issue entries 0..cfg_len-1 in order; with cfg_len=0 the sequence goes MODE -> START.
REQ-027 START SHALL write address 2, data 0.
REQ-028 Each write: mgmt_write, mgmt_address and mgmt_writedata SHALL be held stable until a cycle with mgmt_waitrequest=0, in which the transfer completes.
REQ-029 mgmt_write SHALL be low for exactly one cycle between consecutive transfers.
REQ-030 mgmt_address and mgmt_writedata SHALL be 0 while mgmt_write=0.
REQ-031 BLANK SHALL last 4 cycles after START completes, then go to WAIT_LOCK with the timeout counter cleared.
REQ-032 WAIT_LOCK SHALL declare lock when locked_s=1 for 8 consecutive cycles, then pulse done and return to IDLE.
REQ-033 If the timeout counter reaches TIMEOUT without lock and the retry flag is clear: set the retry flag and enter RECOVER.
REQ-034 If the timeout counter reaches TIMEOUT with the retry flag set: pulse err and return to IDLE.
REQ-035 RECOVER SHALL drive pll_rst=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with the timeout counter cleared.
REQ-036 Lock loss in IDLE (locked_s falls from 1 to 0) SHALL enter RECOVER with the retry flag clear; busy=1 throughout.
REQ-037 The retry flag SHALL clear on entry to MODE and on entry to RECOVER from IDLE.
REQ-038 busy SHALL be 1 in every state except IDLE.
REQ-039 done and err SHALL never assert in the same cycle.

Reset
REQ-040 On rst assertion, independent of clk: state=IDLE, busy=0, done=0, err=0, pll_rst=1, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, synchronizer flops=0, all counters and the retry flag cleared.
REQ-041 After rst deasserts, pll_rst SHALL stay high for RST_CYCLES cycles (state RECOVER); the block then waits for lock with the retry flag set.
REQ-042 rst asserted mid-transfer SHALL drop mgmt_write immediately; no partial sequence SHALL resume after reset.

Verification
REQ-043 cfg_len=2, entries {0x04:0x00000505, 0x05:0x00020202}, waitrequest=0, lock 10 cycles after START -> writes (0,0),(4,0x505),(5,0x20202),(2,0), one-cycle gaps between them, then a done pulse.
REQ-044 waitrequest held high 5 cycles on entry 0 -> address and data stable for all 6 cycles, a single transfer counted.
REQ-045 Lock never returns, TIMEOUT=100 -> one pll_rst pulse of 16 cycles, then a second timeout, then an err pulse; busy=0 afterwards.
REQ-046 IDLE with lock present, then pll_locked dropped -> pll_rst pulse 16 cycles; lock restored -> done pulse, no err.
REQ-047 rst asserted during WRITE of entry 1 -> mgmt_write=0 the same cycle, pll_rst=1, then the RST_CYCLES recovery after release; cfg_go accepted once back in IDLE.
